// File: rtl/branch_pred_table_ctrl_if.sv
// Branch prediction table bus: fetch-stage lookup plus decode-stage update.
// Signals: fetch_pc -> H/P/pred_target (lookup); upd_pc/upd_target/taken/WRt/WRp (update);
//          ready, hit_cnt, upd_cnt (status). master = pipeline side, slave = table controller.
interface branch_pred_table_ctrl_if #(
  parameter int ADDR_W = 32
);
  // Lookup path
  logic [ADDR_W-1:0] fetch_pc;
  logic              H;
  logic              P;
  logic [ADDR_W-1:0] pred_target;
  // Update path
  logic [ADDR_W-1:0] upd_pc;
  logic [ADDR_W-1:0] upd_target;
  logic              taken;
  logic              WRt;
  logic              WRp;
  // Status
  logic              ready;
  logic [15:0]       hit_cnt;
  logic [15:0]       upd_cnt;

  modport master (
    output fetch_pc, upd_pc, upd_target, taken, WRt, WRp,
    input  H, P, pred_target, ready, hit_cnt, upd_cnt
  );

  modport slave (
    input  fetch_pc, upd_pc, upd_target, taken, WRt, WRp,
    output H, P, pred_target, ready, hit_cnt, upd_cnt
  );
endinterface

// File: rtl/branch_pred_table_ctrl.sv
// Direct-mapped branch prediction table with post-reset clear sequencer and perf counters.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries lookup, update and status.
// Lookup is combinational (no bypass of a same-cycle update); updates land on the next edge.
module branch_pred_table_ctrl #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_pred_table_ctrl_if.slave  bus
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Controller state
  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ready_q;

  // Table storage
  logic [N-1:0]      valid_q;
  logic [TAG_W-1:0]  tag_q [N];
  logic [ADDR_W-1:0] tgt_q [N];
  logic [1:0]        ctr_q [N];

  // Performance counters
  logic [15:0]       hit_cnt_q;
  logic [15:0]       upd_cnt_q;
  logic [15:0]       hit_cnt_d;
  logic [15:0]       upd_cnt_d;

  // Address split; PC bits [1:0] carry no information for word-aligned code.
  logic [IDX_W-1:0]  f_idx;
  logic [TAG_W-1:0]  f_tag;
  logic [IDX_W-1:0]  u_idx;
  logic [TAG_W-1:0]  u_tag;
  logic              unused_pc_lsbs;

  assign f_idx          = bus.fetch_pc[IDX_W+1:2];
  assign f_tag          = bus.fetch_pc[ADDR_W-1:IDX_W+2];
  assign u_idx          = bus.upd_pc[IDX_W+1:2];
  assign u_tag          = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup: purely combinational from the current table contents.
  // ---------------------------------------------------------------------------
  logic hit;

  assign hit             = ready_q & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
  assign bus.H           = hit;
  assign bus.P           = hit & ctr_q[f_idx][1];
  assign bus.pred_target = hit ? tgt_q[f_idx] : '0;

  // ---------------------------------------------------------------------------
  // Update decode. WRt wins over WRp; a WRp only applies to a matching valid entry.
  // ---------------------------------------------------------------------------
  logic       do_alloc;
  logic       do_pred;
  logic       u_match;
  logic [1:0] ctr_cur;
  logic [1:0] ctr_d;

  assign u_match  = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
  assign do_alloc = ready_q & bus.WRt;
  assign do_pred  = ready_q & ~bus.WRt & bus.WRp & u_match;
  assign ctr_cur  = ctr_q[u_idx];

  // Two-bit saturating counter step.
  always_comb begin
    ctr_d = ctr_cur;
    if (bus.taken) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller FSM: walk every entry once after reset, then run forever.
  // ready is registered so it rises on the edge that writes the last entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == {IDX_W{1'b1}}) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          idx_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Table write port. Valid bits are cleared at reset so a reset in RUN drops
  // every entry immediately; the remaining fields are scrubbed by the INIT walk.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (state_q == ST_INIT) begin
      valid_q[idx_q] <= 1'b0;
      tag_q[idx_q]   <= '0;
      tgt_q[idx_q]   <= '0;
      ctr_q[idx_q]   <= 2'b01;
    end else if (do_alloc) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      tgt_q[u_idx]   <= bus.upd_target;
      ctr_q[u_idx]   <= bus.taken ? 2'b10 : 2'b01;
    end else if (do_pred) begin
      ctr_q[u_idx]   <= ctr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters, free-running with natural 16-bit wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    upd_cnt_d = upd_cnt_q;
    if (hit)                 hit_cnt_d = hit_cnt_q + 16'd1;
    if (do_alloc || do_pred) upd_cnt_d = upd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
      upd_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.hit_cnt = hit_cnt_q;
  assign bus.upd_cnt = upd_cnt_q;

endmodule

// File: tb/tb_branch_pred_table_ctrl.sv
// Directed bench for branch_pred_table_ctrl (IDX_W=4, ADDR_W=32).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values below are hand-derived from the table behaviour.
module tb_branch_pred_table_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  branch_pred_table_ctrl_if #(.ADDR_W(32)) bus ();

  branch_pred_table_ctrl #(.IDX_W(4), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_upd();
    bus.WRt = 1'b0;
    bus.WRp = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic eh, input logic ep, input logic [31:0] et);
    bus.fetch_pc = pc;
    #1;
    chk({tag, ".H"}, {31'd0, bus.H}, {31'd0, eh});
    chk({tag, ".P"}, {31'd0, bus.P}, {31'd0, ep});
    chk({tag, ".tgt"}, bus.pred_target, et);
    bus.fetch_pc = 32'h0;  // index 0 / tag 0 is never allocated, so no hits counted
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.fetch_pc   = 32'h40;
    bus.upd_pc     = 32'h0;
    bus.upd_target = 32'h0;
    bus.taken      = 1'b0;
    idle_upd();

    // Reset held for two edges.
    tick();
    tick();
    chk("rst.ready", {31'd0, bus.ready}, 32'd0);
    chk("rst.H", {31'd0, bus.H}, 32'd0);
    chk("rst.hit_cnt", {16'd0, bus.hit_cnt}, 32'd0);
    chk("rst.upd_cnt", {16'd0, bus.upd_cnt}, 32'd0);
    bus.fetch_pc = 32'h0;

    // INIT walk: 15 edges still not ready, the 16th raises ready.
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("init.ready_low", {31'd0, bus.ready}, 32'd0);
    end
    tick();
    chk("init.ready_high", {31'd0, bus.ready}, 32'd1);
    look("run.empty40", 32'h40, 1'b0, 1'b0, 32'h0);

    // Same-cycle allocate + lookup on an invalid entry: pre-update view.
    bus.upd_pc = 32'h84; bus.upd_target = 32'h100; bus.taken = 1'b0; bus.WRt = 1'b1;
    look("same.pre", 32'h84, 1'b0, 1'b0, 32'h0);
    tick();
    idle_upd();
    look("same.post", 32'h84, 1'b1, 1'b0, 32'h100);
    chk("same.upd_cnt", {16'd0, bus.upd_cnt}, 32'd1);

    // Allocate 0x40 -> 0x80, taken (ctr=10).
    bus.upd_pc = 32'h40; bus.upd_target = 32'h80; bus.taken = 1'b1; bus.WRt = 1'b1;
    tick();
    idle_upd();
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h80);
    chk("alloc.upd_cnt", {16'd0, bus.upd_cnt}, 32'd2);
    bus.fetch_pc = 32'h40;
    tick();  // one edge with a hit
    bus.fetch_pc = 32'h0;
    chk("alloc.hit_cnt", {16'd0, bus.hit_cnt}, 32'd1);

    // Saturation up: 10 -> 11 -> 11.
    bus.taken = 1'b1; bus.WRp = 1'b1;
    tick();
    tick();
    idle_upd();
    chk("sat.upd_cnt", {16'd0, bus.upd_cnt}, 32'd4);
    // Down: 11 -> 10 (still taken), 10 -> 01 (not taken).
    bus.taken = 1'b0; bus.WRp = 1'b1;
    tick();
    idle_upd();
    look("sat.dn1", 32'h40, 1'b1, 1'b1, 32'h80);
    bus.WRp = 1'b1;
    tick();
    idle_upd();
    look("sat.dn2", 32'h40, 1'b1, 1'b0, 32'h80);
    chk("sat.upd_cnt2", {16'd0, bus.upd_cnt}, 32'd6);

    // Alias: same index, different tag.
    look("alias.look", 32'h440, 1'b0, 1'b0, 32'h0);
    bus.upd_pc = 32'h440; bus.taken = 1'b1; bus.WRp = 1'b1;
    tick();
    idle_upd();
    chk("alias.upd_cnt", {16'd0, bus.upd_cnt}, 32'd6);
    look("alias.keep40", 32'h40, 1'b1, 1'b0, 32'h80);

    // WRt has priority over WRp: full replace with taken -> ctr=10.
    bus.upd_pc = 32'h40; bus.upd_target = 32'h200; bus.taken = 1'b1;
    bus.WRt = 1'b1; bus.WRp = 1'b1;
    tick();
    idle_upd();
    look("prio", 32'h40, 1'b1, 1'b1, 32'h200);
    chk("prio.upd_cnt", {16'd0, bus.upd_cnt}, 32'd7);

    // Three more hit edges.
    bus.fetch_pc = 32'h40;
    tick();
    tick();
    tick();
    bus.fetch_pc = 32'h0;
    chk("hits.hit_cnt", {16'd0, bus.hit_cnt}, 32'd4);

    // Reset in RUN drops everything.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rrun.ready", {31'd0, bus.ready}, 32'd0);
    chk("rrun.hit_cnt", {16'd0, bus.hit_cnt}, 32'd0);
    chk("rrun.upd_cnt", {16'd0, bus.upd_cnt}, 32'd0);

    // Reset again once INIT has reached idx=7.
    for (int i = 0; i < 7; i++) tick();
    chk("rinit.ready_pre", {31'd0, bus.ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // A full 16-edge walk must follow; an update issued mid-INIT is ignored.
    for (int i = 0; i < 15; i++) begin
      if (i == 10) begin
        bus.upd_pc = 32'h40; bus.upd_target = 32'h80; bus.taken = 1'b1; bus.WRt = 1'b1;
      end else begin
        idle_upd();
      end
      tick();
    end
    idle_upd();
    chk("rinit.ready_low", {31'd0, bus.ready}, 32'd0);
    tick();
    chk("rinit.ready_high", {31'd0, bus.ready}, 32'd1);
    look("rinit.empty40", 32'h40, 1'b0, 1'b0, 32'h0);
    look("rinit.empty84", 32'h84, 1'b0, 1'b0, 32'h0);
    chk("rinit.upd_cnt", {16'd0, bus.upd_cnt}, 32'd0);
    chk("rinit.hit_cnt", {16'd0, bus.hit_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_pred_table_ctrl.md
# branch_pred_table_ctrl

Branch prediction table and its controller for the MIPS pipeline. Holds a direct-mapped table of branch entries (valid, tag, target, 2-bit saturating counter). Answers the fetch-stage lookup with hit (H), prediction (P) and predicted target, and applies the tag/prediction write requests (WRt/WRp) raised by the branch unit in decode. After reset it sequences a clear of every entry before it reports ready, and it keeps hit/update performance counters.

## Interface

Parameters:
- IDX_W, 4: index width; table has 2^IDX_W entries
- ADDR_W, 32: PC/target width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- fetch_pc  in  ADDR_W  PC of instruction in fetch
- H  out  1  lookup hit
- P  out  1  predicted taken (counter MSB of hit entry)
- pred_target  out  ADDR_W  target of hit entry, 0 on miss
- upd_pc  in  ADDR_W  PC of branch in decode
- upd_target  in  ADDR_W  computed branch target
- taken  in  1  branch outcome (comparator result C)
- WRt  in  1  allocate/replace entry (write tag, target, counter)
- WRp  in  1  update prediction counter
- ready  out  1  table initialised, lookups/updates active
- hit_cnt  out  16  number of cycles with H=1, wraps
- upd_cnt  out  16  number of accepted updates, wraps

## Operation

- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. PC bits [1:0] ignored.
- FSM states: INIT, RUN.
  - INIT: clear counter idx starts at 0; each cycle writes valid=0, tag=0, target=0, ctr=2'b01 at idx; idx increments. After writing idx = 2^IDX_W-1, go to RUN. ready=0 in INIT.
  - RUN: ready=1; lookups and updates active. Stays in RUN until rst.
- rst=1 in any state (including mid-INIT) → INIT with idx=0, counters cleared; INIT restarts from entry 0.
- Lookup (combinational from table registers and fetch_pc): H = ready & valid[i] & (tag[i]==fetch tag); P = H & ctr[i][1]; pred_target = H ? target[i] : 0.
- Update (RUN only, ignored in INIT), indexed by upd_pc:
  - WRt=1 (WRp don't care): valid=1, tag, target=upd_target, ctr = taken ? 2'b10 : 2'b01. Overwrites any existing entry.
  - WRt=0, WRp=1: if valid & tag match, ctr saturating +1 when taken, −1 when not taken (11 stays 11, 00 stays 00); target not changed. Tag mismatch or invalid → no change, not counted.
  - WRt=0, WRp=0: no change.
- upd_cnt increments on every applied write (WRt, or WRp with match); hit_cnt increments on every RUN cycle with H=1. Both wrap 0xFFFF→0.

## Timing

- Reset values: ready=0, H=0, P=0, pred_target=0, hit_cnt=0, upd_cnt=0, all entries invalid.
- INIT lasts exactly 2^IDX_W cycles after the first edge with rst=0; ready is 1 from the following cycle (IDX_W=4: ready=1 after 16 edges).
- Lookup: zero latency, combinational from current table state.
- Update: written at the rising edge of the cycle in which WRt/WRp is sampled; visible to lookup from the next cycle.
- Same-cycle update and lookup on the same index: lookup returns the pre-update entry (no bypass).
- Only one update port; WRt has priority over WRp.

## Test plan

- Reset, IDX_W=4: rst high 2 cycles, then low → ready=0 for 16 cycles, then 1; H=0 for any fetch_pc; counters 0.
- Allocate: upd_pc=0x40, upd_target=0x80, taken=1, WRt=1 → next cycle fetch_pc=0x40 gives H=1, P=1, pred_target=0x80; upd_cnt=1.
- Saturation: after allocate with taken=1 (ctr=10), WRp/taken=1 twice → ctr 11, stays 11; then WRp/taken=0 twice → ctr 01, P=0.
- Alias: entry for 0x40 valid; fetch_pc=0x440 (same index, other tag) → H=0, P=0, pred_target=0; WRp with upd_pc=0x440 → no change, upd_cnt unchanged.
- Same-cycle: fetch_pc=upd_pc=0x40 with WRt=1, taken=0 on an invalid entry → H=0 that cycle, H=1/P=0 next cycle.
- Reset mid-INIT and mid-RUN: rst at INIT idx=7 → INIT restarts, ready after a further 16 cycles; rst in RUN → all entries invalid, hit_cnt/upd_cnt=0.
